branch_predict_unit: RTL and testbench
======================================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath and PC width.
REQ-002 Parameter ENTRIES, default 64, number of BTB/PHT entries; power of two, at least 4.
REQ-003 Parameter TAG_BITS, default 8, BTB tag width.
REQ-004 Parameter GHR_BITS, default 6, global history width; used only under BP_GSHARE_EN; at most log2(ENTRIES).
REQ-005 Port clk  in  1  single clock; all state changes on the rising edge.
REQ-006 Port reset_n  in  1  asynchronous, active-low reset.
REQ-007 Port f_in_pc  in  XLEN  fetch PC.
REQ-008 Port f_out_pred_taken  out  1  prediction: taken.
REQ-009 Port f_out_pred_target  out  XLEN  predicted target; 0 when f_out_pred_taken=0.
REQ-010 Port f_out_pred_index  out  log2(ENTRIES)  PHT index used for this prediction; the pipeline carries it to execute.
REQ-011 Port e_in_update_en  in  1  resolved branch or jump in execute, not flushed.
REQ-012 Port e_in_is_jmp  in  1  resolved instruction is an unconditional jump.
REQ-013 Port e_in_pc, e_in_pc_plus4, e_in_target  in  XLEN each  resolved instruction PC, PC+4 and computed target.
REQ-014 Port e_in_taken  in  1  actual outcome; forced to 1 by the pipeline for jumps.
REQ-015 Port e_in_pred_taken, e_in_pred_target, e_in_pred_index  in  1/XLEN/log2(ENTRIES)  prediction carried from fetch.
REQ-016 Port bp_out_redirect_en  out  1  mispredict; fetch redirect and D/E flush required.
REQ-017 Port bp_out_redirect_pc  out  XLEN  correct next PC.
REQ-018 Port bp_out_mispredict_count  out  32  saturating mispredict counter.

Function
REQ-019 BTB entry fields: valid, tag, target (XLEN), selected by btb_idx = f_in_pc[log2(ENTRIES)+1:2]; tag = the next TAG_BITS PC bits above the index.
REQ-020 PHT: ENTRIES x 2-bit saturating counters; 00/01 predict not-taken, 10/11 predict taken.
REQ-021 Prediction is combinational from f_in_pc and current state, with zero-cycle latency; taken = BTB valid AND tag match AND PHT[pred_index][1].
REQ-022 Without BP_GSHARE_EN, pred_index = btb_idx.
REQ-023 Update occurs on the clk edge when e_in_update_en=1; no other state changes, except reset.
REQ-024 BTB hit at e_in_pc, taken: target <= e_in_target, PHT[e_in_pred_index] increments with saturation at 11.
REQ-025 BTB hit, not taken: PHT[e_in_pred_index] decrements with saturation at 00; BTB unchanged.
REQ-026 BTB miss or invalid, taken: allocate (valid=1, tag, target); PHT[e_in_pred_index] <= 10.
REQ-027 BTB miss, not taken: no table write.
REQ-028 Jump (e_in_is_jmp=1): PHT[e_in_pred_index] <= 11 regardless of prior value.
REQ-029 Mispredict = e_in_update_en AND (e_in_pred_taken != e_in_taken OR (e_in_taken AND e_in_pred_target != e_in_target)); combinational.
REQ-030 bp_out_redirect_pc = e_in_taken ? e_in_target : e_in_pc_plus4; 0 when no mispredict.
REQ-031 bp_out_mispredict_count increments by 1 per mispredicted update and holds at 0xFFFFFFFF.
REQ-032 Same-cycle read and update of one entry: the prediction uses pre-update contents; the new contents are visible from the next cycle.
REQ-033 Aliasing entries (index match, tag mismatch) are overwritten on a taken update; no replacement policy beyond this.

Reset
REQ-034 reset_n=0 immediately clears all BTB valid bits, sets all PHT counters to 01, clears the GHR and bp_out_mispredict_count.
REQ-035 During reset, f_out_pred_taken=0, f_out_pred_target=0 and bp_out_redirect_en=0; any update in flight is discarded.
REQ-036 Reset release requires no warm-up cycle; prediction is valid in the first cycle after release.

Configuration
REQ-037 Macro BP_GSHARE_EN, when defined, adds a GHR_BITS-wide global history register.
REQ-038 With BP_GSHARE_EN, pred_index = btb_idx XOR zero-extended GHR; the BTB stays indexed by btb_idx.
REQ-039 With BP_GSHARE_EN, the GHR shifts left on each update with e_in_is_jmp=0, taking e_in_taken in at bit 0; jumps do not shift it.
REQ-040 Without BP_GSHARE_EN, no GHR exists, and pred_index = btb_idx.

Verification
REQ-041 Reset, f_in_pc=0x100 -> f_out_pred_taken=0, count=0.
REQ-042 Update pc=0x100, taken=1, target=0x80, pred_taken=0 -> redirect_en=1, redirect_pc=0x80, count=1; next cycle f_in_pc=0x100 -> taken=1, target=0x80.
REQ-043 Three further taken updates at 0x100 then four not-taken -> counter 11 then 00; prediction not-taken; the fourth not-taken update reports no mispredict.
REQ-044 Alias: allocate 0x100 (ENTRIES=64), then taken update at 0x200 -> 0x100 misses and 0x200 hits.
REQ-045 Update and read of 0x100 in the same cycle -> old prediction that cycle, new one the next cycle; reset_n pulsed mid-sequence -> all entries invalid.
REQ-046 BP_GSHARE_EN: alternating T/N branch at 0x40 with GHR_BITS=2 -> after warm-up, zero mispredicts over 8 updates.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch predictor: direct-mapped BTB plus 2-bit PHT, with a mispredict detector for execute.
// Optional gshare indexing of the PHT is enabled by defining BP_GSHARE_EN.
module branch_predict_unit #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 8,
    parameter int GHR_BITS = 6
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [XLEN-1:0]            f_in_pc,
    output logic                       f_out_pred_taken,
    output logic [XLEN-1:0]            f_out_pred_target,
    output logic [$clog2(ENTRIES)-1:0] f_out_pred_index,
    input  logic                       e_in_update_en,
    input  logic                       e_in_is_jmp,
    input  logic [XLEN-1:0]            e_in_pc,
    input  logic [XLEN-1:0]            e_in_pc_plus4,
    input  logic [XLEN-1:0]            e_in_target,
    input  logic                       e_in_taken,
    input  logic                       e_in_pred_taken,
    input  logic [XLEN-1:0]            e_in_pred_target,
    input  logic [$clog2(ENTRIES)-1:0] e_in_pred_index,
    output logic                       bp_out_redirect_en,
    output logic [XLEN-1:0]            bp_out_redirect_pc,
    output logic [31:0]                bp_out_mispredict_count
);

    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_LSB = IDX_W + 2;

    logic [ENTRIES-1:0]  btb_valid_q, btb_valid_d;
    logic [TAG_BITS-1:0] btb_tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_d    [ENTRIES];
    logic [XLEN-1:0]     btb_target_q [ENTRIES];
    logic [XLEN-1:0]     btb_target_d [ENTRIES];
    logic [1:0]          pht_q        [ENTRIES];
    logic [1:0]          pht_d        [ENTRIES];
    logic [31:0]         mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0]    f_idx;
    logic [TAG_BITS-1:0] f_tag;
    logic                f_hit;
    logic [IDX_W-1:0]    pred_index;
    logic [1:0]          f_ctr;

    logic [IDX_W-1:0]    e_idx;
    logic [TAG_BITS-1:0] e_tag;
    logic                e_hit;
    logic                mispredict;

    // PC bits outside the index/tag fields carry no information for the tables.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{f_in_pc, e_in_pc};

    // ---------------- fetch-side lookup ----------------
    assign f_idx = f_in_pc[TAG_LSB-1:2];
    assign f_tag = f_in_pc[TAG_LSB +: TAG_BITS];
    assign f_hit = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    assign pred_index = f_idx ^ IDX_W'(ghr_q);

    // Only conditional branches enter the history; jumps would dilute it.
    always_comb begin
        ghr_d = ghr_q;
        if (e_in_update_en && !e_in_is_jmp) begin
            ghr_d = (ghr_q << 1) | GHR_BITS'(e_in_taken);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    logic [GHR_BITS-1:0] unused_ghr;
    assign unused_ghr = '0;
    assign pred_index = f_idx;
`endif

    assign f_ctr             = pht_q[pred_index];
    assign f_out_pred_index  = pred_index;
    assign f_out_pred_taken  = reset_n && f_hit && f_ctr[1];
    assign f_out_pred_target = f_out_pred_taken ? btb_target_q[f_idx] : '0;

    // ---------------- execute-side resolution ----------------
    assign e_idx = e_in_pc[TAG_LSB-1:2];
    assign e_tag = e_in_pc[TAG_LSB +: TAG_BITS];
    assign e_hit = btb_valid_q[e_idx] && (btb_tag_q[e_idx] == e_tag);

    assign mispredict = reset_n && e_in_update_en &&
                        ((e_in_pred_taken != e_in_taken) ||
                         (e_in_taken && (e_in_pred_target != e_in_target)));

    assign bp_out_redirect_en      = mispredict;
    assign bp_out_redirect_pc      = mispredict ? (e_in_taken ? e_in_target : e_in_pc_plus4) : '0;
    assign bp_out_mispredict_count = mispredict_count_q;

    always_comb begin
        mispredict_count_d = mispredict_count_q;
        if (mispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    // Table update. A taken update on an aliasing entry simply takes it over.
    always_comb begin
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        pht_d        = pht_q;
        if (e_in_update_en) begin
            if (e_in_taken) begin
                btb_valid_d[e_idx]  = 1'b1;
                btb_tag_d[e_idx]    = e_tag;
                btb_target_d[e_idx] = e_in_target;
                if (e_hit) begin
                    if (pht_q[e_in_pred_index] != 2'b11) begin
                        pht_d[e_in_pred_index] = pht_q[e_in_pred_index] + 2'd1;
                    end
                end else begin
                    pht_d[e_in_pred_index] = 2'b10;
                end
            end else if (e_hit) begin
                if (pht_q[e_in_pred_index] != 2'b00) begin
                    pht_d[e_in_pred_index] = pht_q[e_in_pred_index] - 2'd1;
                end
            end
            if (e_in_is_jmp) begin
                pht_d[e_in_pred_index] = 2'b11;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btb_valid_q        <= '0;
            mispredict_count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
                pht_q[i]        <= 2'b01;
            end
        end else begin
            btb_valid_q        <= btb_valid_d;
            btb_tag_q          <= btb_tag_d;
            btb_target_q       <= btb_target_d;
            pht_q              <= pht_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: randomized updates against a table-level reference model.
module tb_branch_predict_unit;

    localparam int XLEN     = 32;
    localparam int ENTRIES  = 64;
    localparam int TAG_BITS = 8;
    localparam int GHR_BITS = 2;
    localparam int IDX_W    = 6;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [XLEN-1:0]   f_in_pc;
    logic              f_out_pred_taken;
    logic [XLEN-1:0]   f_out_pred_target;
    logic [IDX_W-1:0]  f_out_pred_index;
    logic              e_in_update_en;
    logic              e_in_is_jmp;
    logic [XLEN-1:0]   e_in_pc;
    logic [XLEN-1:0]   e_in_pc_plus4;
    logic [XLEN-1:0]   e_in_target;
    logic              e_in_taken;
    logic              e_in_pred_taken;
    logic [XLEN-1:0]   e_in_pred_target;
    logic [IDX_W-1:0]  e_in_pred_index;
    logic              bp_out_redirect_en;
    logic [XLEN-1:0]   bp_out_redirect_pc;
    logic [31:0]       bp_out_mispredict_count;

    int checks = 0;
    int errors = 0;

    branch_predict_unit #(
        .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .GHR_BITS(GHR_BITS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .f_in_pc(f_in_pc),
        .f_out_pred_taken(f_out_pred_taken), .f_out_pred_target(f_out_pred_target),
        .f_out_pred_index(f_out_pred_index), .e_in_update_en(e_in_update_en),
        .e_in_is_jmp(e_in_is_jmp), .e_in_pc(e_in_pc), .e_in_pc_plus4(e_in_pc_plus4),
        .e_in_target(e_in_target), .e_in_taken(e_in_taken),
        .e_in_pred_taken(e_in_pred_taken), .e_in_pred_target(e_in_pred_target),
        .e_in_pred_index(e_in_pred_index), .bp_out_redirect_en(bp_out_redirect_en),
        .bp_out_redirect_pc(bp_out_redirect_pc), .bp_out_mispredict_count(bp_out_mispredict_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_valid [ENTRIES];
    int          m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_count;
    int          m_ghr;

    logic        exp_mis;
    logic [31:0] exp_rpc;
    int          cur_pidx;

    function automatic int m_bidx(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int m_tagof(input logic [31:0] pc);
        return int'((pc / (4 * ENTRIES)) % (1 << TAG_BITS));
    endfunction

    function automatic int m_pidx(input logic [31:0] pc);
`ifdef BP_GSHARE_EN
        return m_bidx(pc) ^ m_ghr;
`else
        return m_bidx(pc);
`endif
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_bidx(pc)] && (m_tag[m_bidx(pc)] == m_tagof(pc));
    endfunction

    function automatic logic m_pred_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_pidx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
        return m_pred_taken(pc) ? m_tgt[m_bidx(pc)] : 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_count = '0;
        m_ghr   = 0;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic taken,
                                input logic [31:0] target, input logic jmp, input int pidx);
        int b;
        bit hit;
        b   = m_bidx(pc);
        hit = m_hit(pc);
        if (taken) begin
            if (hit) begin
                m_tgt[b]    = target;
                m_ctr[pidx] = (m_ctr[pidx] + 1 > 3) ? 3 : m_ctr[pidx] + 1;
            end else begin
                m_valid[b]  = 1'b1;
                m_tag[b]    = m_tagof(pc);
                m_tgt[b]    = target;
                m_ctr[pidx] = 2;
            end
        end else if (hit) begin
            m_ctr[pidx] = (m_ctr[pidx] - 1 < 0) ? 0 : m_ctr[pidx] - 1;
        end
        if (jmp) m_ctr[pidx] = 3;
`ifdef BP_GSHARE_EN
        if (!jmp) m_ghr = ((m_ghr << 1) | int'(taken)) % (1 << GHR_BITS);
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_update(input logic [31:0] pc, input logic taken,
                                input logic [31:0] target, input logic jmp);
        logic        pt;
        logic [31:0] ptg;
        logic        tk;
        tk       = taken | jmp;
        pt       = m_pred_taken(pc);
        ptg      = m_pred_target(pc);
        cur_pidx = m_pidx(pc);
        e_in_update_en   = 1'b1;
        e_in_is_jmp      = jmp;
        e_in_pc          = pc;
        e_in_pc_plus4    = pc + 32'd4;
        e_in_target      = target;
        e_in_taken       = tk;
        e_in_pred_taken  = pt;
        e_in_pred_target = ptg;
        e_in_pred_index  = IDX_W'(cur_pidx);
        exp_mis = (pt != tk) || (tk && (ptg != target));
        exp_rpc = exp_mis ? (tk ? target : pc + 32'd4) : 32'h0;
    endtask

    task automatic commit();
        @(posedge clk);
        model_update(e_in_pc, e_in_taken, e_in_target, e_in_is_jmp, cur_pidx);
        if (exp_mis && (m_count != 32'hFFFF_FFFF)) m_count = m_count + 32'd1;
        #1;
        e_in_update_en = 1'b0;
        e_in_is_jmp    = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        model_reset();
        f_in_pc = 32'h100;
        drive_update(32'h100, 1'b1, 32'h80, 1'b0);
        #1;
        checks++;
        if (f_out_pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred_taken got %0h exp 0", f_out_pred_taken); end
        checks++;
        if (f_out_pred_target !== 32'h0) begin errors++; $display("FAIL rst_pred_target got %0h exp 0", f_out_pred_target); end
        checks++;
        if (bp_out_redirect_en !== 1'b0) begin errors++; $display("FAIL rst_redirect_en got %0h exp 0", bp_out_redirect_en); end
        checks++;
        if (bp_out_redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect_pc got %0h exp 0", bp_out_redirect_pc); end
        @(posedge clk);
        #1 e_in_update_en = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (f_out_pred_taken !== 1'b0) begin errors++; $display("FAIL post_rst_pred got %0h exp 0", f_out_pred_taken); end
        checks++;
        if (bp_out_mispredict_count !== 32'h0) begin errors++; $display("FAIL post_rst_count got %0h exp 0", bp_out_mispredict_count); end
    endtask

    task automatic test_basic();
        f_in_pc = 32'h100;
        drive_update(32'h100, 1'b1, 32'h80, 1'b0);
        #2;
        checks++;
        if (bp_out_redirect_en !== exp_mis) begin errors++; $display("FAIL basic_redirect_en got %0h exp %0h", bp_out_redirect_en, exp_mis); end
        checks++;
        if (bp_out_redirect_pc !== exp_rpc) begin errors++; $display("FAIL basic_redirect_pc got %0h exp %0h", bp_out_redirect_pc, exp_rpc); end
        commit();
        checks++;
        if (bp_out_mispredict_count !== m_count) begin errors++; $display("FAIL basic_count got %0h exp %0h", bp_out_mispredict_count, m_count); end
        checks++;
        if (f_out_pred_taken !== m_pred_taken(32'h100)) begin errors++; $display("FAIL basic_pred_taken got %0h exp %0h", f_out_pred_taken, m_pred_taken(32'h100)); end
        checks++;
        if (f_out_pred_target !== m_pred_target(32'h100)) begin errors++; $display("FAIL basic_pred_target got %0h exp %0h", f_out_pred_target, m_pred_target(32'h100)); end
    endtask

    task automatic test_counter();
        for (int i = 0; i < 7; i++) begin
            f_in_pc = 32'h100;
            drive_update(32'h100, (i < 3), 32'h80, 1'b0);
            #2;
            checks++;
            if (bp_out_redirect_en !== exp_mis) begin errors++; $display("FAIL ctr_redirect_en[%0d] got %0h exp %0h", i, bp_out_redirect_en, exp_mis); end
            checks++;
            if (bp_out_redirect_pc !== exp_rpc) begin errors++; $display("FAIL ctr_redirect_pc[%0d] got %0h exp %0h", i, bp_out_redirect_pc, exp_rpc); end
            checks++;
            if (f_out_pred_taken !== e_in_pred_taken) begin errors++; $display("FAIL ctr_pred[%0d] got %0h exp %0h", i, f_out_pred_taken, e_in_pred_taken); end
            commit();
        end
        #1;
        checks++;
        if (f_out_pred_taken !== m_pred_taken(32'h100)) begin errors++; $display("FAIL ctr_final_pred got %0h exp %0h", f_out_pred_taken, m_pred_taken(32'h100)); end
        checks++;
        if (bp_out_mispredict_count !== m_count) begin errors++; $display("FAIL ctr_count got %0h exp %0h", bp_out_mispredict_count, m_count); end
    endtask

    task automatic test_alias();
        drive_update(32'h100, 1'b1, 32'h80, 1'b0);
        commit();
        drive_update(32'h200, 1'b1, 32'h2000, 1'b0);
        commit();
        f_in_pc = 32'h100;
        #1;
        checks++;
        if (f_out_pred_taken !== m_pred_taken(32'h100)) begin errors++; $display("FAIL alias_old_pred got %0h exp %0h", f_out_pred_taken, m_pred_taken(32'h100)); end
        f_in_pc = 32'h200;
        #1;
        checks++;
        if (f_out_pred_taken !== m_pred_taken(32'h200)) begin errors++; $display("FAIL alias_new_pred got %0h exp %0h", f_out_pred_taken, m_pred_taken(32'h200)); end
        checks++;
        if (f_out_pred_target !== m_pred_target(32'h200)) begin errors++; $display("FAIL alias_new_target got %0h exp %0h", f_out_pred_target, m_pred_target(32'h200)); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_same_cycle_and_reset();
        logic        old_taken;
        logic [31:0] old_tgt;
        for (int i = 0; i < 2; i++) begin
            f_in_pc   = 32'h300;
            old_taken = m_pred_taken(32'h300);
            old_tgt   = m_pred_target(32'h300);
            drive_update(32'h300, (i == 0), 32'h1234, 1'b0);
            #2;
            checks++;
            if (f_out_pred_taken !== old_taken) begin errors++; $display("FAIL same_old_pred[%0d] got %0h exp %0h", i, f_out_pred_taken, old_taken); end
            checks++;
            if (f_out_pred_target !== old_tgt) begin errors++; $display("FAIL same_old_target[%0d] got %0h exp %0h", i, f_out_pred_target, old_tgt); end
            commit();
            checks++;
            if (f_out_pred_taken !== m_pred_taken(32'h300)) begin errors++; $display("FAIL same_new_pred[%0d] got %0h exp %0h", i, f_out_pred_taken, m_pred_taken(32'h300)); end
        end
        drive_update(32'h300, 1'b1, 32'h1234, 1'b1);
        commit();
        // Asynchronous reset pulse in the middle of a cycle.
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (f_out_pred_taken !== 1'b0) begin errors++; $display("FAIL midrst_pred got %0h exp 0", f_out_pred_taken); end
        checks++;
        if (bp_out_mispredict_count !== 32'h0) begin errors++; $display("FAIL midrst_count got %0h exp 0", bp_out_mispredict_count); end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) begin
            f_in_pc = 32'h0 + 32'(k * 4) + 32'h100 * 32'(k % 4);
            #1;
            checks++;
            if (f_out_pred_taken !== 1'b0) begin errors++; $display("FAIL midrst_invalid pc %0h got %0h exp 0", f_in_pc, f_out_pred_taken); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] pool [8];
        logic [31:0] tgts [4];
        logic [31:0] pc;
        logic        jmp;
        logic [IDX_W-1:0] eidx;
        pool[0] = 32'h100;  pool[1] = 32'h200;  pool[2] = 32'h104;  pool[3] = 32'h300;
        pool[4] = 32'h40;   pool[5] = 32'h1100; pool[6] = 32'h2040; pool[7] = 32'h8;
        for (int j = 0; j < 4; j++) tgts[j] = $urandom & 32'hFFFF_FFFC;
        for (int n = 0; n < 300; n++) begin
            f_in_pc = pool[$urandom_range(0, 7)];
            pc      = pool[$urandom_range(0, 7)];
            jmp     = ($urandom_range(0, 7) == 0);
            drive_update(pc, $urandom_range(0, 1) == 1, tgts[$urandom_range(0, 3)], jmp);
            #2;
            eidx = IDX_W'(m_pidx(f_in_pc));
            checks++;
            if (f_out_pred_taken !== m_pred_taken(f_in_pc)) begin errors++; $display("FAIL rnd_pred_taken[%0d] pc %0h got %0h exp %0h", n, f_in_pc, f_out_pred_taken, m_pred_taken(f_in_pc)); end
            checks++;
            if (f_out_pred_target !== m_pred_target(f_in_pc)) begin errors++; $display("FAIL rnd_pred_target[%0d] got %0h exp %0h", n, f_out_pred_target, m_pred_target(f_in_pc)); end
            checks++;
            if (f_out_pred_index !== eidx) begin errors++; $display("FAIL rnd_pred_index[%0d] got %0h exp %0h", n, f_out_pred_index, eidx); end
            checks++;
            if (bp_out_redirect_en !== exp_mis) begin errors++; $display("FAIL rnd_redirect_en[%0d] got %0h exp %0h", n, bp_out_redirect_en, exp_mis); end
            checks++;
            if (bp_out_redirect_pc !== exp_rpc) begin errors++; $display("FAIL rnd_redirect_pc[%0d] got %0h exp %0h", n, bp_out_redirect_pc, exp_rpc); end
            commit();
            checks++;
            if (bp_out_mispredict_count !== m_count) begin errors++; $display("FAIL rnd_count[%0d] got %0h exp %0h", n, bp_out_mispredict_count, m_count); end
        end
    endtask

`ifdef BP_GSHARE_EN
    task automatic test_gshare_alternating();
        int late_mis;
        late_mis = 0;
        @(negedge clk) reset_n = 1'b0;
        model_reset();
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 24; n++) begin
            f_in_pc = 32'h40;
            drive_update(32'h40, (n % 2 == 0), 32'h400, 1'b0);
            #2;
            checks++;
            if (bp_out_redirect_en !== exp_mis) begin errors++; $display("FAIL gs_redirect_en[%0d] got %0h exp %0h", n, bp_out_redirect_en, exp_mis); end
            if (n >= 16 && bp_out_redirect_en === 1'b1) late_mis++;
            commit();
        end
        checks++;
        if (late_mis != 0) begin errors++; $display("FAIL gs_steady_mispredicts got %0d exp 0", late_mis); end
    endtask
`endif

    initial begin
        reset_n          = 1'b1;
        f_in_pc          = '0;
        e_in_update_en   = 1'b0;
        e_in_is_jmp      = 1'b0;
        e_in_pc          = '0;
        e_in_pc_plus4    = '0;
        e_in_target      = '0;
        e_in_taken       = 1'b0;
        e_in_pred_taken  = 1'b0;
        e_in_pred_target = '0;
        e_in_pred_index  = '0;
        model_reset();
        test_reset();
        test_basic();
        test_counter();
        test_alias();
        test_same_cycle_and_reset();
        test_back_to_back_random();
`ifdef BP_GSHARE_EN
        test_gshare_alternating();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
